// File: rtl/pipelined_rr_arbiter_if.sv
// Bundles the client-side and server-side signals of the pipelined round-robin arbiter.
// The arbiter uses modport slave; the environment that drives it uses modport master.
interface pipelined_rr_arbiter_if #(
  parameter int req_data_width    = 16,
  parameter int server_data_width = 16,
  parameter int n_clients         = 8,
  parameter int max_outstanding   = 4
);
  localparam int cnt_w = $clog2(max_outstanding + 1);

  logic [req_data_width-1:0]    req_data [n_clients];
  logic [n_clients-1:0]         reqs;
  logic [server_data_width-1:0] data_out;
  logic [n_clients-1:0]         readies;
  logic [req_data_width-1:0]    arbiter_req_data;
  logic                         arbiter_req;
  logic                         server_accept;
  logic [server_data_width-1:0] server_data;
  logic                         server_valid;
  logic [cnt_w-1:0]             outstanding;
  logic                         protocol_error;

  modport slave (
    input  req_data, reqs, server_accept, server_data, server_valid,
    output data_out, readies, arbiter_req_data, arbiter_req, outstanding, protocol_error
  );

  modport master (
    output req_data, reqs, server_accept, server_data, server_valid,
    input  data_out, readies, arbiter_req_data, arbiter_req, outstanding, protocol_error
  );
endinterface

// File: rtl/pipelined_rr_arbiter.sv
// Skip-idle round-robin arbiter sharing one in-order pipelined server among n_clients,
// with a tag FIFO of depth max_outstanding that routes each response back to its owner.
module pipelined_rr_arbiter #(
  parameter int req_data_width    = 16,
  parameter int server_data_width = 16,
  parameter int n_clients         = 8,
  parameter int max_outstanding   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  pipelined_rr_arbiter_if.slave  bus
);
  localparam int idx_w = $clog2(n_clients);
  localparam int cnt_w = $clog2(max_outstanding + 1);
  localparam int fp_w  = (max_outstanding > 1) ? $clog2(max_outstanding) : 1;

  logic [idx_w-1:0]             ptr_q, ptr_d;
  logic [n_clients-1:0]         pending_q, pending_d;
  logic [idx_w-1:0]             tag_q [max_outstanding];
  logic [fp_w-1:0]              rd_q, rd_d, wr_q, wr_d;
  logic [cnt_w-1:0]             cnt_q, cnt_d;
  logic                         arb_req_q, arb_req_d;
  logic [req_data_width-1:0]    arb_data_q, arb_data_d;
  logic [server_data_width-1:0] dout_q, dout_d;
  logic [n_clients-1:0]         ready_q, ready_d;
  logic                         perr_q, perr_d;

  logic [n_clients-1:0]         elig_s;
  logic [idx_w-1:0]             cand_s;
  logic [idx_w-1:0]             gnt_idx_s;
  logic                         found_s;
  logic                         hit_s;
  logic                         slot_free_s;
  logic                         grant_s;
  logic                         pop_s;
  logic [idx_w-1:0]             head_s;

  function automatic logic [fp_w-1:0] next_fp(input logic [fp_w-1:0] p);
    return (p == fp_w'(max_outstanding - 1)) ? {fp_w{1'b0}} : p + fp_w'(1);
  endfunction

  function automatic logic [n_clients-1:0] onehot(input logic [idx_w-1:0] k);
    return {{(n_clients-1){1'b0}}, 1'b1} << k;
  endfunction

  // Scan from the pointer upward, wrapping, for the first eligible client.
  always_comb begin
    elig_s    = bus.reqs & ~pending_q;
    found_s   = 1'b0;
    gnt_idx_s = ptr_q;
    cand_s    = ptr_q;
    hit_s     = 1'b0;
    for (int i = 0; i < n_clients; i++) begin
      cand_s    = idx_w'((int'(ptr_q) + i) % n_clients);
      hit_s     = !found_s && elig_s[cand_s];
      gnt_idx_s = hit_s ? cand_s : gnt_idx_s;
      found_s   = found_s | hit_s;
    end
  end

  // A pop does not free a slot within its own cycle, so the grant uses the pre-pop count.
  always_comb begin
    slot_free_s = !arb_req_q || bus.server_accept;
    grant_s     = found_s && slot_free_s && (cnt_q < cnt_w'(max_outstanding));
    pop_s       = bus.server_valid && (cnt_q != cnt_w'(0));
    head_s      = tag_q[rd_q];

    ptr_d      = grant_s ? ((gnt_idx_s == idx_w'(n_clients - 1)) ? {idx_w{1'b0}}
                                                                  : gnt_idx_s + idx_w'(1))
                         : ptr_q;
    pending_d  = (pending_q & ~ready_q) | (grant_s ? onehot(gnt_idx_s) : {n_clients{1'b0}});
    wr_d       = grant_s ? next_fp(wr_q) : wr_q;
    rd_d       = pop_s ? next_fp(rd_q) : rd_q;
    ready_d    = pop_s ? onehot(head_s) : {n_clients{1'b0}};
    dout_d     = pop_s ? bus.server_data : dout_q;
    perr_d     = perr_q | (bus.server_valid && (cnt_q == cnt_w'(0)));
    arb_req_d  = arb_req_q;
    arb_data_d = arb_data_q;
    cnt_d      = cnt_q;

    case ({grant_s, pop_s})
      2'b10:   cnt_d = cnt_q + cnt_w'(1);
      2'b01:   cnt_d = cnt_q - cnt_w'(1);
      default: cnt_d = cnt_q;
    endcase

    if (grant_s) begin
      arb_req_d  = 1'b1;
      arb_data_d = bus.req_data[gnt_idx_s];
    end else if (arb_req_q && bus.server_accept) begin
      arb_req_d  = 1'b0;
      arb_data_d = arb_data_q;
    end else begin
      arb_req_d  = arb_req_q;
      arb_data_d = arb_data_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= {idx_w{1'b0}};
      pending_q  <= {n_clients{1'b0}};
      rd_q       <= {fp_w{1'b0}};
      wr_q       <= {fp_w{1'b0}};
      cnt_q      <= {cnt_w{1'b0}};
      arb_req_q  <= 1'b0;
      arb_data_q <= {req_data_width{1'b0}};
      dout_q     <= {server_data_width{1'b0}};
      ready_q    <= {n_clients{1'b0}};
      perr_q     <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      pending_q  <= pending_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      arb_req_q  <= arb_req_d;
      arb_data_q <= arb_data_d;
      dout_q     <= dout_d;
      ready_q    <= ready_d;
      perr_q     <= perr_d;
    end
  end

  // Tag storage; each entry holds the client id of one granted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < max_outstanding; i++) begin
        tag_q[i] <= {idx_w{1'b0}};
      end
    end else if (grant_s) begin
      tag_q[wr_q] <= gnt_idx_s;
    end else begin
      tag_q[wr_q] <= tag_q[wr_q];
    end
  end

  assign bus.data_out         = dout_q;
  assign bus.readies          = ready_q;
  assign bus.arbiter_req_data = arb_data_q;
  assign bus.arbiter_req      = arb_req_q;
  assign bus.outstanding      = cnt_q;
  assign bus.protocol_error   = perr_q;
endmodule

// File: tb/tb_pipelined_rr_arbiter.sv
// Directed and randomized bench for pipelined_rr_arbiter against a queue-based reference model.
module tb_pipelined_rr_arbiter;
  localparam int RW = 16;
  localparam int SW = 16;
  localparam int N  = 8;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic reset;

  pipelined_rr_arbiter_if #(.req_data_width(RW), .server_data_width(SW),
                            .n_clients(N), .max_outstanding(MO)) bus ();

  pipelined_rr_arbiter #(.req_data_width(RW), .server_data_width(SW),
                         .n_clients(N), .max_outstanding(MO)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: in-flight tags as a queue, pending as a flag array.
  int          m_ptr;
  bit          m_pend [N];
  int          m_tags [$];
  bit          m_req;
  logic [RW-1:0] m_data;
  int          m_rtag;
  logic [SW-1:0] m_dout;
  bit          m_perr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_tags.delete();
    m_req  = 1'b0;
    m_data = '0;
    m_rtag = -1;
    m_dout = '0;
    m_perr = 1'b0;
  endtask

  task automatic model_step();
    int size0;
    int k;
    size0 = m_tags.size();
    k = -1;
    if (size0 < MO && (!m_req || bus.server_accept)) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (k < 0 && bus.reqs[c] && !m_pend[c]) k = c;
      end
    end
    if (m_rtag >= 0) m_pend[m_rtag] = 1'b0;
    if (bus.server_valid && size0 == 0) m_perr = 1'b1;
    if (bus.server_valid && size0 > 0) begin
      m_rtag = m_tags.pop_front();
      m_dout = bus.server_data;
    end else begin
      m_rtag = -1;
    end
    if (k >= 0) begin
      m_tags.push_back(k);
      m_pend[k] = 1'b1;
      m_ptr  = (k + 1) % N;
      m_req  = 1'b1;
      m_data = bus.req_data[k];
    end else if (m_req && bus.server_accept) begin
      m_req = 1'b0;
    end
  endtask

  task automatic compare();
    chk("arb_req", 32'(bus.arbiter_req), 32'(m_req));
    if (m_req) chk("arb_data", 32'(bus.arbiter_req_data), 32'(m_data));
    chk("readies", 32'(bus.readies), (m_rtag >= 0) ? (32'd1 << m_rtag) : 32'd0);
    if (m_rtag >= 0) chk("data_out", 32'(bus.data_out), 32'(m_dout));
    chk("outstanding", 32'(bus.outstanding), 32'(m_tags.size()));
    chk("perr", 32'(bus.protocol_error), 32'(m_perr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_step();
    compare();
  endtask

  task automatic clear_inputs();
    bus.reqs = '0;
    bus.server_accept = 1'b1;
    bus.server_valid = 1'b0;
    bus.server_data = '0;
    for (int k = 0; k < N; k++) bus.req_data[k] = RW'(16'h1000 + k);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
  endtask

  int due [$];
  int cyc;
  bit was_acc;
  bit spurious_done;

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #1;
    chk("rst_arb_req", 32'(bus.arbiter_req), 32'd0);
    chk("rst_outstanding", 32'(bus.outstanding), 32'd0);
    do_reset();

    // Single request.
    bus.reqs = 8'h04; bus.req_data[2] = 16'h1234;
    tick();
    chk("t1_req", 32'(bus.arbiter_req), 32'd1);
    chk("t1_data", 32'(bus.arbiter_req_data), 32'h1234);
    tick();
    chk("t1_req_drop", 32'(bus.arbiter_req), 32'd0);
    tick(); tick();
    bus.server_valid = 1'b1; bus.server_data = 16'hBEEF;
    tick();
    chk("t1_ready", 32'(bus.readies), 32'h04);
    chk("t1_dout", 32'(bus.data_out), 32'hBEEF);
    bus.server_valid = 1'b0; bus.reqs = 8'h00;
    tick();
    chk("t1_out0", 32'(bus.outstanding), 32'd0);

    // All clients requesting, responses delayed.
    do_reset();
    bus.reqs = 8'hFF;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("t2_grant", 32'(bus.arbiter_req_data), 32'h1000 + 32'(g));
    end
    tick();
    chk("t2_stall_req", 32'(bus.arbiter_req), 32'd0);
    chk("t2_stall_out", 32'(bus.outstanding), 32'd4);
    bus.server_valid = 1'b1; bus.server_data = 16'hA000;
    tick();
    chk("t2_ready0", 32'(bus.readies), 32'h01);
    bus.server_valid = 1'b0;
    tick();
    chk("t2_next_grant", 32'(bus.arbiter_req_data), 32'h1004);
    for (int r = 1; r < 4; r++) begin
      bus.server_valid = 1'b1; bus.server_data = SW'(16'hA000 + r);
      tick();
      chk("t2_ready_order", 32'(bus.readies), 32'd1 << r);
      chk("t2_dout", 32'(bus.data_out), 32'hA000 + 32'(r));
    end
    bus.server_valid = 1'b0;

    // Skip-idle with wrap from pointer 6.
    do_reset();
    bus.req_data[5] = 16'h5555; bus.req_data[7] = 16'h7777; bus.req_data[1] = 16'h1111;
    bus.reqs = 8'h20;
    tick(); tick();
    bus.server_valid = 1'b1;
    tick();
    chk("t3_ready5", 32'(bus.readies), 32'h20);
    bus.server_valid = 1'b0; bus.reqs = 8'h82;
    tick();
    chk("t3_grant7", 32'(bus.arbiter_req_data), 32'h7777);
    tick();
    chk("t3_grant1_req", 32'(bus.arbiter_req), 32'd1);
    chk("t3_grant1", 32'(bus.arbiter_req_data), 32'h1111);

    // Backpressure.
    do_reset();
    bus.server_accept = 1'b0; bus.req_data[0] = 16'hABCD; bus.req_data[3] = 16'h3333;
    bus.reqs = 8'h09;
    tick();
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("t4_hold_data", 32'(bus.arbiter_req_data), 32'hABCD);
      chk("t4_hold_out", 32'(bus.outstanding), 32'd1);
    end
    bus.server_accept = 1'b1;
    tick();
    chk("t4_next", 32'(bus.arbiter_req_data), 32'h3333);
    chk("t4_out2", 32'(bus.outstanding), 32'd2);

    // Response while full: no grant in that cycle, grant follows.
    do_reset();
    bus.reqs = 8'hFF;
    repeat (5) tick();
    chk("t5_full", 32'(bus.outstanding), 32'd4);
    bus.server_valid = 1'b1;
    tick();
    chk("t5_no_grant", 32'(bus.arbiter_req), 32'd0);
    bus.server_valid = 1'b0;
    tick();
    chk("t5_grant", 32'(bus.arbiter_req), 32'd1);
    chk("t5_out4", 32'(bus.outstanding), 32'd4);

    // Spurious response, then asynchronous reset mid-burst.
    do_reset();
    bus.server_valid = 1'b1; bus.server_data = 16'hDEAD;
    tick();
    chk("t6_perr", 32'(bus.protocol_error), 32'd1);
    chk("t6_no_ready", 32'(bus.readies), 32'd0);
    bus.server_valid = 1'b0;
    tick();
    chk("t6_perr_sticky", 32'(bus.protocol_error), 32'd1);
    do_reset();
    bus.reqs = 8'hFF;
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("t6_async_req", 32'(bus.arbiter_req), 32'd0);
    chk("t6_async_data", 32'(bus.arbiter_req_data), 32'd0);
    chk("t6_async_out", 32'(bus.outstanding), 32'd0);
    chk("t6_async_ready", 32'(bus.readies), 32'd0);
    chk("t6_async_perr", 32'(bus.protocol_error), 32'd0);
    tick();
    reset = 1'b0;
    bus.reqs = 8'h00;
    bus.server_valid = 1'b1;
    tick();
    chk("t6_late_resp", 32'(bus.protocol_error), 32'd1);
    bus.server_valid = 1'b0;
    do_reset();

    // Randomized traffic with a random-latency in-order server.
    cyc = 0;
    spurious_done = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      was_acc = bus.arbiter_req && bus.server_accept;
      tick();
      cyc++;
      if (was_acc) due.push_back(cyc + int'($urandom_range(0, 5)));
      if (due.size() > 0 && due[0] <= cyc) begin
        void'(due.pop_front());
        bus.server_valid = 1'b1;
        bus.server_data = SW'($urandom);
      end else if (!spurious_done && cyc > 2500 && due.size() == 0 && bus.outstanding == 0) begin
        spurious_done = 1'b1;
        bus.server_valid = 1'b1;
        bus.server_data = SW'($urandom);
      end else begin
        bus.server_valid = 1'b0;
      end
      bus.server_accept = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        if (bus.readies[k]) begin
          bus.reqs[k] = 1'b0;
        end else if (!bus.reqs[k] && $urandom_range(0, 2) == 0) begin
          bus.reqs[k] = 1'b1;
          bus.req_data[k] = RW'($urandom);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
